// File: rtl/scv_rominit_loader.sv
// scv_rominit_loader: turns 16-bit ioctl word writes into the byte-serial
// ROMINIT_* stream. Splits the BIOS image into boot/chr/apu regions, routes
// the cart image to the cart region, and reports BIOS_OK and CART_SIZE.
module scv_rominit_loader #(
  parameter int BOOT_SIZE  = 4096,
  parameter int CHR_SIZE   = 1024,
  parameter int APU_SIZE   = 1024,
  parameter int BIOS_INDEX = 0,
  parameter int CART_INDEX = 1
) (
  input  logic        CLK,
  input  logic        RESB,
  input  logic        IOCTL_DOWNLOAD,
  input  logic [7:0]  IOCTL_INDEX,
  input  logic [24:0] IOCTL_ADDR,
  input  logic [15:0] IOCTL_DOUT,
  input  logic        IOCTL_WR,
  output logic        IOCTL_WAIT,
  output logic        ROMINIT_SEL_BOOT,
  output logic        ROMINIT_SEL_CHR,
  output logic        ROMINIT_SEL_APU,
  output logic        ROMINIT_SEL_CART,
  output logic [24:0] ROMINIT_ADDR,
  output logic [7:0]  ROMINIT_DATA,
  output logic        ROMINIT_VALID,
  output logic        ROMINIT_ACTIVE,
  output logic        BIOS_OK,
  output logic [24:0] CART_SIZE
);

  localparam logic [7:0]  BIOS_IDX = 8'(BIOS_INDEX);
  localparam logic [7:0]  CART_IDX = 8'(CART_INDEX);
  localparam logic [24:0] BOOT_END = 25'(BOOT_SIZE);
  localparam logic [24:0] CHR_END  = 25'(BOOT_SIZE + CHR_SIZE);
  localparam logic [24:0] APU_END  = 25'(BOOT_SIZE + CHR_SIZE + APU_SIZE);
  localparam int          TOTAL    = BOOT_SIZE + CHR_SIZE + APU_SIZE;
  localparam int          CNT_W    = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);

  // Select vector order: {cart, apu, chr, boot}
  localparam logic [3:0] SEL_BOOT = 4'b0001;
  localparam logic [3:0] SEL_CHR  = 4'b0010;
  localparam logic [3:0] SEL_APU  = 4'b0100;
  localparam logic [3:0] SEL_CART = 4'b1000;

  typedef enum logic [1:0] {IDLE, EMIT_LO, EMIT_HI} state_t;

  state_t             state_q;
  logic [24:0]        addr_q;
  logic [7:0]         hi_q;
  logic [7:0]         idx_q;
  logic               wait_q;
  logic               active_q;
  logic               valid_q;
  logic [3:0]         sel_q;
  logic [24:0]        raddr_q;
  logic [7:0]         data_q;
  logic               dl_q;
  logic               dl_bios_q;
  logic               eval_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               bios_ok_q;
  logic [24:0]        cart_size_q;

  logic               accept;
  logic               emit_en;
  logic [7:0]         byte_idx;
  logic [24:0]        byte_addr;
  logic [7:0]         byte_data;
  logic [3:0]         byte_sel;
  logic [24:0]        byte_raddr;
  logic               byte_valid;
  logic               dl_rise;
  logic               dl_fall;
  logic               bios_byte;
  logic               cart_hi;
  logic [24:0]        cart_end;

  // Byte currently being emitted (low byte straight from the host, high byte
  // from the latched word) and its region decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    accept     = (state_q == IDLE) && IOCTL_WR && IOCTL_DOWNLOAD;
    emit_en    = accept || (state_q == EMIT_LO);
    byte_idx   = (state_q == EMIT_LO) ? idx_q : IOCTL_INDEX;
    byte_addr  = (state_q == EMIT_LO) ? (addr_q + 25'd1) : IOCTL_ADDR;
    byte_data  = (state_q == EMIT_LO) ? hi_q : IOCTL_DOUT[7:0];
    byte_sel   = 4'b0000;
    byte_raddr = byte_addr;
    if (byte_idx == BIOS_IDX) begin
      if (byte_addr < BOOT_END) begin
        byte_sel   = SEL_BOOT;
      end else if (byte_addr < CHR_END) begin
        byte_sel   = SEL_CHR;
        byte_raddr = byte_addr - BOOT_END;
      end else if (byte_addr < APU_END) begin
        byte_sel   = SEL_APU;
        byte_raddr = byte_addr - CHR_END;
      end
    end else if (byte_idx == CART_IDX) begin
      byte_sel = SEL_CART;
    end
    byte_valid = emit_en && (byte_sel != 4'b0000);
    bios_byte  = byte_valid && (byte_idx == BIOS_IDX);
    cart_hi    = (state_q == EMIT_LO) && (idx_q == CART_IDX);
    cart_end   = addr_q + 25'd2;
    dl_rise    = IOCTL_DOWNLOAD && !dl_q;
    dl_fall    = !IOCTL_DOWNLOAD && dl_q;
  end

  // Word handshake FSM with registered WAIT/ACTIVE and byte outputs.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      hi_q     <= '0;
      idx_q    <= '0;
      wait_q   <= 1'b0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
      sel_q    <= '0;
      raddr_q  <= '0;
      data_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      wait_q   <= emit_en;
      active_q <= emit_en || (IOCTL_DOWNLOAD &&
                  ((IOCTL_INDEX == BIOS_IDX) || (IOCTL_INDEX == CART_IDX)));
      valid_q  <= byte_valid;
      if (emit_en) begin
        sel_q <= byte_sel;
      end
      if (byte_valid) begin
        raddr_q <= byte_raddr;
        data_q  <= byte_data;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= IOCTL_ADDR;
            hi_q    <= IOCTL_DOUT[15:8];
            idx_q   <= IOCTL_INDEX;
            state_q <= EMIT_LO;
          end
        end
        EMIT_LO: state_q <= EMIT_HI;
        EMIT_HI: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Download status: BIOS byte count / BIOS_OK and cart size tracking.
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      dl_q        <= 1'b0;
      dl_bios_q   <= 1'b0;
      eval_q      <= 1'b0;
      cnt_q       <= '0;
      bios_ok_q   <= 1'b0;
      cart_size_q <= '0;
    end else begin
      dl_q <= IOCTL_DOWNLOAD;
      if (dl_rise) begin
        dl_bios_q <= (IOCTL_INDEX == BIOS_IDX);
      end

      if (dl_rise && (IOCTL_INDEX == BIOS_IDX)) begin
        cnt_q <= '0;
      end else if (bios_byte && (cnt_q != TOTAL_C)) begin
        cnt_q <= cnt_q + 1'b1;
      end

      // The verdict is deferred until the last latched word has drained.
      if (dl_rise && (IOCTL_INDEX == BIOS_IDX)) begin
        bios_ok_q <= 1'b0;
        eval_q    <= 1'b0;
      end else if (eval_q && (state_q == IDLE)) begin
        bios_ok_q <= (cnt_q == TOTAL_C);
        eval_q    <= 1'b0;
      end else if (dl_fall && dl_bios_q) begin
        eval_q <= 1'b1;
      end

      if (dl_rise && (IOCTL_INDEX == CART_IDX)) begin
        cart_size_q <= '0;
      end else if (cart_hi && (cart_end > cart_size_q)) begin
        cart_size_q <= cart_end;
      end
    end
  end

  assign IOCTL_WAIT       = wait_q;
  assign ROMINIT_SEL_BOOT = sel_q[0];
  assign ROMINIT_SEL_CHR  = sel_q[1];
  assign ROMINIT_SEL_APU  = sel_q[2];
  assign ROMINIT_SEL_CART = sel_q[3];
  assign ROMINIT_ADDR     = raddr_q;
  assign ROMINIT_DATA     = data_q;
  assign ROMINIT_VALID    = valid_q;
  assign ROMINIT_ACTIVE   = active_q;
  assign BIOS_OK          = bios_ok_q;
  assign CART_SIZE        = cart_size_q;

endmodule

// File: tb/tb_scv_rominit_loader.sv
// Bench for scv_rominit_loader: table of single-word vectors, image streams
// checked byte-by-byte through an expected-byte queue, and hand sequences for
// handshake timing, ignored strobes, foreign index and mid-word reset.
module tb_scv_rominit_loader;

  localparam logic [7:0] BIOS = 8'd0;
  localparam logic [7:0] CART = 8'd1;

  logic        CLK = 1'b0;
  logic        RESB = 1'b0;
  logic        IOCTL_DOWNLOAD = 1'b0;
  logic [7:0]  IOCTL_INDEX = 8'd0;
  logic [24:0] IOCTL_ADDR = '0;
  logic [15:0] IOCTL_DOUT = '0;
  logic        IOCTL_WR = 1'b0;
  logic        IOCTL_WAIT;
  logic        ROMINIT_SEL_BOOT, ROMINIT_SEL_CHR, ROMINIT_SEL_APU, ROMINIT_SEL_CART;
  logic [24:0] ROMINIT_ADDR;
  logic [7:0]  ROMINIT_DATA;
  logic        ROMINIT_VALID;
  logic        ROMINIT_ACTIVE;
  logic        BIOS_OK;
  logic [24:0] CART_SIZE;

  scv_rominit_loader dut (
    .CLK(CLK), .RESB(RESB),
    .IOCTL_DOWNLOAD(IOCTL_DOWNLOAD), .IOCTL_INDEX(IOCTL_INDEX),
    .IOCTL_ADDR(IOCTL_ADDR), .IOCTL_DOUT(IOCTL_DOUT), .IOCTL_WR(IOCTL_WR),
    .IOCTL_WAIT(IOCTL_WAIT),
    .ROMINIT_SEL_BOOT(ROMINIT_SEL_BOOT), .ROMINIT_SEL_CHR(ROMINIT_SEL_CHR),
    .ROMINIT_SEL_APU(ROMINIT_SEL_APU), .ROMINIT_SEL_CART(ROMINIT_SEL_CART),
    .ROMINIT_ADDR(ROMINIT_ADDR), .ROMINIT_DATA(ROMINIT_DATA),
    .ROMINIT_VALID(ROMINIT_VALID), .ROMINIT_ACTIVE(ROMINIT_ACTIVE),
    .BIOS_OK(BIOS_OK), .CART_SIZE(CART_SIZE)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct packed {
    logic        ok;
    logic [3:0]  sel;   // {cart, apu, chr, boot}
    logic [24:0] addr;
    logic [7:0]  data;
  } exp_t;

  typedef struct {
    logic [7:0]  idx;
    logic [24:0] addr;
    logic [15:0] dout;
    logic        lo_ok;
    logic [3:0]  lo_sel;
    logic [24:0] lo_addr;
    logic        hi_ok;
    logic [3:0]  hi_sel;
    logic [24:0] hi_addr;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];
  bit   mon_en = 1'b1;
  int   seen_sel[4];

  logic [3:0]  sel_now;
  logic [65:0] all_out;
  assign sel_now = {ROMINIT_SEL_CART, ROMINIT_SEL_APU, ROMINIT_SEL_CHR, ROMINIT_SEL_BOOT};
  assign all_out = {IOCTL_WAIT, sel_now, ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_VALID,
                    ROMINIT_ACTIVE, BIOS_OK, CART_SIZE};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] img_byte(input int i);
    return 8'((i * 7) ^ (i >> 8));
  endfunction

  // Reference region map for the default 4096/1024/1024 layout.
  function automatic exp_t model(input logic [7:0] idx, input logic [24:0] b,
                                 input logic [7:0] d);
    exp_t e;
    e = '{ok: 1'b0, sel: 4'b0000, addr: b, data: d};
    if (idx == BIOS) begin
      if (b < 25'd4096)      begin e.ok = 1'b1; e.sel = 4'b0001; end
      else if (b < 25'd5120) begin e.ok = 1'b1; e.sel = 4'b0010; e.addr = b - 25'd4096; end
      else if (b < 25'd6144) begin e.ok = 1'b1; e.sel = 4'b0100; e.addr = b - 25'd5120; end
    end else if (idx == CART) begin
      e.ok = 1'b1; e.sel = 4'b1000;
    end
    return e;
  endfunction

  task automatic push_word(input logic [7:0] idx, input logic [24:0] a, input logic [15:0] w);
    exp_t e;
    e = model(idx, a, w[7:0]);
    if (e.ok) exp_q.push_back(e);
    e = model(idx, a + 25'd1, w[15:8]);
    if (e.ok) exp_q.push_back(e);
  endtask

  // Compare every presented byte with the oldest expected byte.
  always @(negedge CLK) begin
    if (mon_en && ROMINIT_VALID) begin
      for (int k = 0; k < 4; k++) seen_sel[k] += int'(sel_now[k]);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: got sel=0x%0h addr=0x%0h data=0x%0h, expected no byte",
                 sel_now, ROMINIT_ADDR, ROMINIT_DATA);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("byte", {sel_now, ROMINIT_ADDR, ROMINIT_DATA}, {e.sel, e.addr, e.data});
      end
    end
  end

  // Drive one word strobe once WAIT is low (bounded wait).
  task automatic send_word(input logic [7:0] idx, input logic [24:0] a, input logic [15:0] w);
    int t;
    t = 0;
    @(negedge CLK);
    while (IOCTL_WAIT && t < 20) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 20) begin
      n_checks++;
      $display("FAIL wait_timeout: got WAIT stuck high for %0d cycles, expected release", t);
    end
    IOCTL_INDEX = idx;
    IOCTL_ADDR  = a;
    IOCTL_DOUT  = w;
    IOCTL_WR    = 1'b1;
    @(negedge CLK);
    IOCTL_WR = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge CLK);
    IOCTL_INDEX    = idx;
    IOCTL_DOWNLOAD = 1'b1;
    @(negedge CLK);
  endtask

  task automatic end_dl();
    @(negedge CLK);
    IOCTL_DOWNLOAD = 1'b0;
    repeat (8) @(negedge CLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic stream(input logic [7:0] idx, input int nbytes);
    logic [15:0] w;
    for (int a = 0; a < nbytes; a += 2) begin
      w = {img_byte(a + 1), img_byte(a)};
      push_word(idx, 25'(a), w);
      send_word(idx, 25'(a), w);
    end
  endtask

  vec_t vecs[11];
  int   bad;

  initial begin
    vecs[0]  = '{BIOS, 25'h0000FFE, 16'h1122, 1, 4'b0001, 25'h0FFE, 1, 4'b0001, 25'h0FFF};
    vecs[1]  = '{BIOS, 25'h0001000, 16'h3344, 1, 4'b0010, 25'h0000, 1, 4'b0010, 25'h0001};
    vecs[2]  = '{BIOS, 25'h00013FE, 16'h5566, 1, 4'b0010, 25'h03FE, 1, 4'b0010, 25'h03FF};
    vecs[3]  = '{BIOS, 25'h0001400, 16'h7788, 1, 4'b0100, 25'h0000, 1, 4'b0100, 25'h0001};
    vecs[4]  = '{BIOS, 25'h00017FE, 16'h99AA, 1, 4'b0100, 25'h03FE, 1, 4'b0100, 25'h03FF};
    vecs[5]  = '{BIOS, 25'h0001800, 16'hBBCC, 0, 4'b0000, 25'h0,    0, 4'b0000, 25'h0};
    vecs[6]  = '{CART, 25'h01ABCDE, 16'hDDEE, 1, 4'b1000, 25'h1ABCDE, 1, 4'b1000, 25'h1ABCDF};
    vecs[7]  = '{CART, 25'h1FFFFFE, 16'hBEEF, 1, 4'b1000, 25'h1FFFFFE, 1, 4'b1000, 25'h1FFFFFF};
    vecs[8]  = '{8'd5, 25'h0000000, 16'h1234, 0, 4'b0000, 25'h0,    0, 4'b0000, 25'h0};
    vecs[9]  = '{BIOS, 25'h1FFFFFE, 16'h5678, 0, 4'b0000, 25'h0,    0, 4'b0000, 25'h0};
    vecs[10] = '{BIOS, 25'h0000ABC, 16'h0F0F, 1, 4'b0001, 25'h0ABC, 1, 4'b0001, 25'h0ABD};

    // Reset and quiet idle
    repeat (3) @(negedge CLK);
    check("reset_outputs", 128'(all_out), 128'd0);
    RESB = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge CLK);
      if (all_out != '0) bad++;
    end
    check("idle_quiet", bad, 0);

    // Single-word timing: WAIT and the two bytes line up cycle by cycle
    start_dl(BIOS);
    check("active_bios", ROMINIT_ACTIVE, 1'b1);
    @(negedge CLK);
    IOCTL_INDEX = BIOS; IOCTL_ADDR = 25'h0; IOCTL_DOUT = 16'hA55A; IOCTL_WR = 1'b1;
    push_word(BIOS, 25'h0, 16'hA55A);
    @(negedge CLK);
    IOCTL_WR = 1'b0;
    check("lo_byte_timing", {ROMINIT_VALID, IOCTL_WAIT, sel_now, ROMINIT_ADDR, ROMINIT_DATA},
          {1'b1, 1'b1, 4'b0001, 25'h0, 8'h5A});
    @(negedge CLK);
    check("hi_byte_timing", {ROMINIT_VALID, IOCTL_WAIT, sel_now, ROMINIT_ADDR, ROMINIT_DATA},
          {1'b1, 1'b1, 4'b0001, 25'h1, 8'hA5});
    @(negedge CLK);
    check("after_word_hold", {ROMINIT_VALID, IOCTL_WAIT, sel_now, ROMINIT_ADDR, ROMINIT_DATA},
          {1'b0, 1'b0, 4'b0001, 25'h1, 8'hA5});

    // Vector table: region boundaries, cart, foreign index, out-of-range
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].lo_ok) exp_q.push_back('{1'b1, vecs[i].lo_sel, vecs[i].lo_addr, vecs[i].dout[7:0]});
      if (vecs[i].hi_ok) exp_q.push_back('{1'b1, vecs[i].hi_sel, vecs[i].hi_addr, vecs[i].dout[15:8]});
      send_word(vecs[i].idx, vecs[i].addr, vecs[i].dout);
    end
    end_dl();
    check("cart_size_max_wrap", CART_SIZE, 25'h1ABCE0);
    check("bios_ok_partial", BIOS_OK, 1'b0);

    // 6150-byte BIOS: full split, trailing 6 bytes dropped
    for (int k = 0; k < 4; k++) seen_sel[k] = 0;
    start_dl(BIOS);
    stream(BIOS, 6150);
    end_dl();
    check("boot_bytes", seen_sel[0], 4096);
    check("chr_bytes", seen_sel[1], 1024);
    check("apu_bytes", seen_sel[2], 1024);
    check("cart_bytes_in_bios", seen_sel[3], 0);
    check("sel_cleared_on_drop", sel_now, 4'b0000);
    check("bios_ok_full", BIOS_OK, 1'b1);

    // Truncated BIOS
    start_dl(BIOS);
    check("bios_ok_cleared", BIOS_OK, 1'b0);
    stream(BIOS, 6000);
    end_dl();
    check("bios_ok_truncated", BIOS_OK, 1'b0);

    // Odd-length cart, then a smaller cart
    for (int k = 0; k < 4; k++) seen_sel[k] = 0;
    start_dl(CART);
    check("cart_size_cleared", CART_SIZE, 25'h0);
    stream(CART, 32'h8001);
    end_dl();
    check("cart_bytes_odd", seen_sel[3], 32'h8002);
    check("cart_size_odd", CART_SIZE, 25'h8002);
    start_dl(CART);
    check("cart_size_cleared2", CART_SIZE, 25'h0);
    stream(CART, 32'h2000);
    end_dl();
    check("cart_size_small", CART_SIZE, 25'h2000);

    // Extra strobe while busy is ignored
    start_dl(BIOS);
    @(negedge CLK);
    IOCTL_INDEX = BIOS; IOCTL_ADDR = 25'h100; IOCTL_DOUT = 16'h1357; IOCTL_WR = 1'b1;
    push_word(BIOS, 25'h100, 16'h1357);
    @(negedge CLK);
    IOCTL_ADDR = 25'h200; IOCTL_DOUT = 16'hFFFF;
    @(negedge CLK);
    IOCTL_WR = 1'b0;
    repeat (6) @(negedge CLK);
    check("extra_wr_ignored", 32'(exp_q.size()), 32'd0);
    end_dl();

    // Foreign index: handshake only, ACTIVE tracks the busy window
    start_dl(8'd5);
    check("active_foreign_idle", ROMINIT_ACTIVE, 1'b0);
    @(negedge CLK);
    IOCTL_INDEX = 8'd5; IOCTL_ADDR = 25'h10; IOCTL_DOUT = 16'h4242; IOCTL_WR = 1'b1;
    @(negedge CLK);
    IOCTL_WR = 1'b0;
    check("foreign_sel_zero", sel_now, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      check("foreign_wait_active", {IOCTL_WAIT, ROMINIT_ACTIVE, ROMINIT_VALID},
            (k < 2) ? 3'b110 : 3'b000);
      @(negedge CLK);
    end
    end_dl();

    // Reset after the low byte of a word
    start_dl(CART);
    mon_en = 1'b0;
    @(negedge CLK);
    IOCTL_INDEX = CART; IOCTL_ADDR = 25'h40; IOCTL_DOUT = 16'h7788; IOCTL_WR = 1'b1;
    @(negedge CLK);
    IOCTL_WR = 1'b0;
    check("midword_lo", {ROMINIT_VALID, sel_now, ROMINIT_ADDR, ROMINIT_DATA},
          {1'b1, 4'b1000, 25'h40, 8'h88});
    #2 RESB = 1'b0;
    #1 check("midword_reset_outputs", 128'(all_out), 128'd0);
    @(negedge CLK);
    IOCTL_DOWNLOAD = 1'b0;
    repeat (2) @(negedge CLK);
    RESB = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge CLK);
      if (ROMINIT_VALID) bad++;
    end
    check("midword_no_hi_byte", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by time limit, expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
